// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI responder emulating a 4-channel 12-bit SAR ADC, oversampled by clk
module adc_spi_responder #(
    parameter int NUM_CH  = 4,
    parameter int SYNC_FF = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs_n,
    input  logic                   sclk,
    input  logic                   mosi,
    input  logic [12*NUM_CH-1:0]   ch_data,
    output logic                   miso,
    output logic                   miso_oe,
    output logic                   conv_done,
    output logic [2:0]             conv_ch,
    output logic                   conv_sgl,
    output logic [11:0]            conv_data
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        DATA,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_FF-1:0] cs_sync;
    logic [SYNC_FF-1:0] sclk_sync;
    logic [SYNC_FF-1:0] mosi_sync;
    logic               sclk_prev;
    logic               cs_s;
    logic               sclk_s;
    logic               mosi_s;
    logic               rise;
    logic               fall;

    logic [4:0]  rcnt;
    logic        cmd_sgl;
    logic [2:0]  cmd_d;
    logic [11:0] res;
    logic [11:0] shreg;
    logic [11:0] result;

    // cs_n resets high so a held-low pin still needs a fresh detection before a frame starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_FF-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_FF-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_FF-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_FF-1];
        end
    end

    assign cs_s   = cs_sync[SYNC_FF-1];
    assign sclk_s = sclk_sync[SYNC_FF-1];
    assign mosi_s = mosi_sync[SYNC_FF-1];
    assign rise   = sclk_s & ~sclk_prev;
    assign fall   = ~sclk_s & sclk_prev;

    function automatic logic [11:0] pick_ch(input logic [12*NUM_CH-1:0] v, input logic [2:0] idx);
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == 3'(k)) r = v[12*k +: 12];
        end
        return r;
    endfunction

    logic [2:0]  sel_idx;
    logic [1:0]  pair;
    logic [11:0] in_pos;
    logic [11:0] in_neg;
    logic [12:0] diff;

    always_comb begin
        sel_idx = cmd_d & 3'(NUM_CH - 1);
        pair    = cmd_d[2:1] & 2'(NUM_CH / 2 - 1);
        in_pos  = pick_ch(ch_data, {pair, cmd_d[0]});
        in_neg  = pick_ch(ch_data, {pair, ~cmd_d[0]});
        diff    = {1'b0, in_pos} - {1'b0, in_neg};
        if (cmd_sgl) begin
            result = pick_ch(ch_data, sel_idx);
        end else if (diff[12]) begin
            result = 12'd0;
        end else begin
            result = diff[11:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:       state_nxt = WAIT_START;
                WAIT_START: if (rise && mosi_s) state_nxt = CMD;
                CMD:        if (rise && rcnt == 5'd4) state_nxt = SAMPLE;
                SAMPLE:     if (rise) state_nxt = DATA;
                DATA:       if (fall && rcnt == 5'd18) state_nxt = DONE;
                DONE:       state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // rcnt holds the index of the last rising edge, so a fall seen with rcnt==n is Fn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt      <= '0;
            cmd_sgl   <= 1'b0;
            cmd_d     <= '0;
            res       <= '0;
            shreg     <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            conv_done <= 1'b0;
            conv_ch   <= '0;
            conv_sgl  <= 1'b0;
            conv_data <= '0;
        end else begin
            conv_done <= 1'b0;
            if (cs_s) begin
                rcnt    <= '0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    WAIT_START: begin
                        if (rise && mosi_s) rcnt <= 5'd1;
                    end
                    CMD: begin
                        if (rise) begin
                            rcnt <= rcnt + 5'd1;
                            case (rcnt)
                                5'd1:    cmd_sgl  <= mosi_s;
                                5'd2:    cmd_d[2] <= mosi_s;
                                5'd3:    cmd_d[1] <= mosi_s;
                                5'd4:    cmd_d[0] <= mosi_s;
                                default: ;
                            endcase
                        end
                    end
                    SAMPLE: begin
                        if (rise) begin
                            rcnt  <= rcnt + 5'd1;
                            res   <= result;
                            shreg <= result;
                        end
                    end
                    DATA: begin
                        if (rise && rcnt != 5'd31) rcnt <= rcnt + 5'd1;
                        if (fall) begin
                            if (rcnt == 5'd6) begin
                                miso    <= 1'b0;
                                miso_oe <= 1'b1;
                            end else if (rcnt >= 5'd7) begin
                                miso  <= shreg[11];
                                shreg <= {shreg[10:0], 1'b0};
                                if (rcnt == 5'd18) begin
                                    conv_done <= 1'b1;
                                    conv_ch   <= cmd_d;
                                    conv_sgl  <= cmd_sgl;
                                    conv_data <= res;
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (fall) miso <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
